sdram_arbiter: RTL and testbench

//  Shares the single-port SDRAM controller between the CPU (read/write) and the video fetcher
//  (read-only), and schedules periodic auto-refresh. Sits between the bus glue and the SDRAM

---
 rtl/sdram_arbiter_pkg.sv | 22 ++
 rtl/sdram_rfsh_timer.sv | 43 ++++
 rtl/sdram_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// ============================================================================
//  Module  : sdram_arbiter_pkg
//  Brief   : Sequencer states and grant codes shared by the SDRAM arbiter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package sdram_arbiter_pkg;

    localparam logic [1:0] sWAIT = 2'd0;
    localparam logic [1:0] sIDLE = 2'd1;
    localparam logic [1:0] sSLOT = 2'd2;

    typedef logic [1:0] grant_t;

    localparam grant_t gCPU  = 2'd0;
    localparam grant_t gVID  = 2'd1;
    localparam grant_t gRFSH = 2'd2;

endpackage

`default_nettype wire

// File: rtl/sdram_rfsh_timer.sv
// ============================================================================
//  Module  : sdram_rfsh_timer
//  Brief   : Free-running refresh period counter with a single pending flag.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_rfsh_timer #(
    parameter int PERIOD = 780
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic pend
);

    localparam int CW = $clog2(PERIOD);

    logic [CW-1:0] r_cnt;
    logic          r_pend;

    // An expiry while already pending collapses into the same flag; a new
    // expiry beats a simultaneous clear so no period is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else if (r_cnt == CW'(PERIOD - 1)) begin
            r_cnt  <= '0;
            r_pend <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
//  Module  : sdram_arbiter
//  Brief   : Shares one SDRAM controller between CPU and video fetch using
//            fixed-length access slots; optional auto-refresh scheduling
//            enabled by defining SDRAM_ARB_RFSH_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int SLOT_CYCLES = 12,
    parameter int CMD_HOLD    = 2
`ifdef SDRAM_ARB_RFSH_EN
   ,parameter int RFSH_PERIOD = 780
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [21:0] cpu_a,
    input  logic [15:0] cpu_d,
    output logic [15:0] cpu_q,
    output logic        cpu_ack,
    input  logic        vid_req,
    input  logic [21:0] vid_a,
    output logic [15:0] vid_q,
    output logic        vid_ack,
    input  logic        mem_ready,
    output logic [21:0] mem_a,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_rfsh,
    output logic        busy
);

    localparam int CW = $clog2(SLOT_CYCLES);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    grant_t        r_gnt;
    logic          r_last_vid;
    logic          r_we;
    logic          r_busy;
    logic          r_rd;
    logic          r_wr;
    logic          r_rfsh_n;
    logic [15:0]   r_cpu_q;
    logic [15:0]   r_vid_q;
    logic          r_cpu_ack;
    logic          r_vid_ack;
    logic [21:0]   r_mem_a;
    logic [15:0]   r_mem_d;

    logic          w_rfsh_pend;
    logic          w_grant;
    grant_t        w_sel;

`ifdef SDRAM_ARB_RFSH_EN
    logic w_rfsh_clr;

    assign w_rfsh_clr = w_grant && (w_sel == gRFSH);

    sdram_rfsh_timer #(
        .PERIOD (RFSH_PERIOD)
    ) u_rfsh_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (w_rfsh_clr),
        .pend   (w_rfsh_pend)
    );
`else
    assign w_rfsh_pend = 1'b0;
`endif

    // Last-port memory only tracks CPU/video grants, so a refresh slot in
    // between does not reset the alternation.
    always_comb begin
        w_grant = 1'b0;
        w_sel   = gCPU;
        if (r_state == sIDLE) begin
            if (w_rfsh_pend) begin
                w_grant = 1'b1;
                w_sel   = gRFSH;
            end else if (cpu_req && (r_last_vid || !vid_req)) begin
                w_grant = 1'b1;
                w_sel   = gCPU;
            end else if (vid_req) begin
                w_grant = 1'b1;
                w_sel   = gVID;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= sWAIT;
            r_cnt      <= '0;
            r_gnt      <= gCPU;
            r_last_vid <= 1'b0;
            r_we       <= 1'b0;
            r_busy     <= 1'b1;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_rfsh_n   <= 1'b1;
            r_cpu_q    <= '0;
            r_vid_q    <= '0;
            r_cpu_ack  <= 1'b0;
            r_vid_ack  <= 1'b0;
            r_mem_a    <= '0;
            r_mem_d    <= '0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_vid_ack <= 1'b0;
            case (r_state)
                sWAIT: begin
                    // One idle slot after init lets an access cut off by reset drain.
                    if (!mem_ready) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CW'(SLOT_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= sIDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                sIDLE: begin
                    r_busy <= w_grant;
                    if (w_grant) begin
                        r_state <= sSLOT;
                        r_cnt   <= '0;
                        r_gnt   <= w_sel;
                        case (w_sel)
                            gCPU: begin
                                r_mem_a    <= cpu_a;
                                r_mem_d    <= cpu_d;
                                r_we       <= cpu_we;
                                r_rd       <= !cpu_we;
                                r_wr       <= cpu_we;
                                r_last_vid <= 1'b0;
                            end
                            gVID: begin
                                r_mem_a    <= vid_a;
                                r_we       <= 1'b0;
                                r_rd       <= 1'b1;
                                r_last_vid <= 1'b1;
                            end
                            default: begin
                                r_we     <= 1'b0;
                                r_rfsh_n <= 1'b0;
                            end
                        endcase
                    end
                end
                sSLOT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(CMD_HOLD - 1)) begin
                        r_rd     <= 1'b0;
                        r_wr     <= 1'b0;
                        r_rfsh_n <= 1'b1;
                    end
                    if (r_cnt == CW'(SLOT_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= sIDLE;
                        if (r_gnt == gCPU) begin
                            r_cpu_ack <= 1'b1;
                            if (!r_we) begin
                                r_cpu_q <= mem_q;
                            end
                        end else if (r_gnt == gVID) begin
                            r_vid_ack <= 1'b1;
                            r_vid_q   <= mem_q;
                        end
                    end
                end
                default: begin
                    r_state <= sWAIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign cpu_q    = r_cpu_q;
    assign cpu_ack  = r_cpu_ack;
    assign vid_q    = r_vid_q;
    assign vid_ack  = r_vid_ack;
    assign mem_a    = r_mem_a;
    assign mem_d    = r_mem_d;
    assign mem_rd   = r_rd;
    assign mem_wr   = r_wr;
    assign mem_rfsh = r_rfsh_n;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
// ============================================================================
//  Module  : tb_sdram_arbiter
//  Brief   : Scoreboard bench for sdram_arbiter with a controller model;
//            refresh checks follow SDRAM_ARB_RFSH_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdram_arbiter;

    localparam int SLOT = 12;
    localparam int HOLD = 2;
`ifdef SDRAM_ARB_RFSH_EN
    localparam int RP   = 40;
`endif

    typedef struct packed {
        logic        we;
        logic [21:0] a;
        logic [15:0] d;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [21:0] cpu_a = '0, vid_a = '0;
    logic [15:0] cpu_d = '0;
    logic        vid_req = 1'b0, mem_ready = 1'b0;
    logic [15:0] cpu_q, vid_q, mem_d, mem_q;
    logic [21:0] mem_a;
    logic        cpu_ack, vid_ack, mem_rd, mem_wr, mem_rfsh, busy;

    int checks = 0, failures = 0, cyc = 0;
    bit mon_en = 1'b0;
    txn_t cpu_exp[$], vid_exp[$];
    logic [15:0] m_cpu_q = '0, m_vid_q = '0;
    bit m_last_vid = 1'b0;
    bit rfsh_bad = 1'b0;
    int rfsh_seen = 0;
    logic [15:0] bfm_mem [0:1023];
    bit bfm_pwr = 1'b0;

    sdram_arbiter #(
        .SLOT_CYCLES (SLOT),
        .CMD_HOLD    (HOLD)
`ifdef SDRAM_ARB_RFSH_EN
       ,.RFSH_PERIOD (RP)
`endif
    ) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_d(cpu_d),
        .cpu_q(cpu_q), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_a(vid_a), .vid_q(vid_q), .vid_ack(vid_ack),
        .mem_ready(mem_ready), .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rfsh(mem_rfsh), .busy(busy)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Controller model: stores on a write edge, read data is the inverted address.
    assign mem_q = ~mem_a[15:0];
    initial forever begin
        @(negedge clock);
        if (mem_wr && !bfm_pwr) bfm_mem[mem_a[9:0]] = mem_d;
        bfm_pwr = mem_wr;
        if (mem_rfsh !== 1'b1) rfsh_bad = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
    endtask

    task automatic cpu_issue(input logic we, input logic [21:0] a, input logic [15:0] d);
        cpu_we = we; cpu_a = a; cpu_d = d; cpu_req = 1'b1;
        cpu_exp.push_back('{we: we, a: a, d: d});
    endtask

    task automatic vid_issue(input logic [21:0] a);
        vid_a = a; vid_req = 1'b1;
        vid_exp.push_back('{we: 1'b0, a: a, d: 16'h0});
    endtask

    task automatic wait_cpu_ack(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clock);
            if (cpu_ack) ok = 1'b1;
        end
        if (!ok) fail("cpu_ack_timeout");
    endtask

    task automatic wait_vid_ack(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clock);
            if (vid_ack) ok = 1'b1;
        end
        if (!ok) fail("vid_ack_timeout");
    endtask

    // Monitor: the arbitration rule is applied to the request levels seen at
    // the grant edge; each slot must close with the right ack after SLOT clocks.
    initial begin
        bit p_act = 1'b0, act, slot_open = 1'b0;
        int s_len = 0, slot_start = 0, slot_port = 0, last_rf = -1;
        txn_t t;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                slot_open = 1'b0; s_len = 0; p_act = 1'b0; last_rf = -1;
            end else begin
                act = mem_rd || mem_wr || !mem_rfsh;
                if (act) s_len++;
                else if (p_act) begin
                    chk("strobe_len", s_len, HOLD);
                    s_len = 0;
                end
                if (act && !p_act) begin
                    chk("busy_in_slot", busy, 1);
                    if (!mem_rfsh) begin
                        slot_port = 2;
                        rfsh_seen++;
                        chk("rfsh_exclusive", {30'd0, mem_rd, mem_wr}, 0);
`ifdef SDRAM_ARB_RFSH_EN
                        if (last_rf >= 0)
                            chk("rfsh_interval", ((cyc - last_rf) >= RP - SLOT - 2) &&
                                ((cyc - last_rf) <= RP + SLOT + 2), 1);
`endif
                        last_rf = cyc;
                    end else if (cpu_req && (m_last_vid || !vid_req)) begin
                        slot_port = 0;
                        m_last_vid = 1'b0;
                        if (cpu_exp.size() == 0) fail("cpu_grant_unrequested");
                        else begin
                            chk("cpu_mem_a", mem_a, cpu_exp[0].a);
                            chk("cpu_strobe", {mem_rd, mem_wr}, cpu_exp[0].we ? 2'b01 : 2'b10);
                            if (cpu_exp[0].we) chk("cpu_mem_d", mem_d, cpu_exp[0].d);
                        end
                    end else if (vid_req) begin
                        slot_port = 1;
                        m_last_vid = 1'b1;
                        if (vid_exp.size() == 0) fail("vid_grant_unrequested");
                        else begin
                            chk("vid_mem_a", mem_a, vid_exp[0].a);
                            chk("vid_strobe", {mem_rd, mem_wr}, 2'b10);
                        end
                    end else begin
                        slot_port = 3;
                        fail("grant_without_request");
                    end
                    slot_open = 1'b1;
                    slot_start = cyc;
                end
                if (slot_open && (cyc - slot_start == SLOT)) begin
                    chk("cpu_ack_at_slot_end", cpu_ack, slot_port == 0);
                    chk("vid_ack_at_slot_end", vid_ack, slot_port == 1);
                    if (slot_port == 0 && cpu_ack && cpu_exp.size() > 0) begin
                        t = cpu_exp.pop_front();
                        if (!t.we) m_cpu_q = ~t.a[15:0];
                        else chk("bfm_write_data", bfm_mem[t.a[9:0]], t.d);
                        chk("cpu_q", cpu_q, m_cpu_q);
                    end
                    if (slot_port == 1 && vid_ack && vid_exp.size() > 0) begin
                        t = vid_exp.pop_front();
                        m_vid_q = ~t.a[15:0];
                        chk("vid_q", vid_q, m_vid_q);
                    end
                    slot_open = 1'b0;
                end else if (cpu_ack || vid_ack) begin
                    fail("spurious_ack");
                end
                p_act = act;
            end
        end
    end

    task automatic run_cpu(input int n);
        bit ok;
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                cpu_req = 1'b0;
                repeat (gap) @(negedge clock);
                #1;
            end
            cpu_issue(1'($urandom_range(0, 1)), 22'($urandom), 16'($urandom));
            wait_cpu_ack(ok);
            if (!ok) break;
            #1;
        end
        cpu_req = 1'b0;
    endtask

    task automatic run_vid(input int n);
        bit ok;
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                vid_req = 1'b0;
                repeat (gap) @(negedge clock);
                #1;
            end
            vid_issue(22'($urandom));
            wait_vid_ack(ok);
            if (!ok) break;
            #1;
        end
        vid_req = 1'b0;
    endtask

    initial begin
        bit ok, strobe_early;
        int c0, n;
        int order [3];
        int tack [3];

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_cpu_q", cpu_q, 0);
        chk("rst_vid_q", vid_q, 0);
        chk("rst_acks", {cpu_ack, vid_ack}, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_d", mem_d, 0);
        chk("rst_strobes", {mem_rd, mem_wr, mem_rfsh}, 3'b001);
        chk("rst_busy", busy, 1);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        // Init wait: busy drops one slot after mem_ready, no strobes before that
        c0 = cyc;
        strobe_early = 1'b0;
        while (cyc < c0 + 20) begin
            @(negedge clock);
            if (mem_rd || mem_wr || !mem_rfsh || !busy) strobe_early = 1'b1;
        end
        #1 mem_ready = 1'b1;
        c0 = cyc;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clock);
            if (!busy) ok = 1'b1;
            else if (mem_rd || mem_wr || !mem_rfsh) strobe_early = 1'b1;
        end
        chk("init_busy_delay", cyc - c0, SLOT);
        chk("no_strobe_during_init", strobe_early, 0);

        // Single CPU write
        #1 cpu_issue(1'b1, 22'h000123, 16'hBEEF);
        c0 = cyc;
        wait_cpu_ack(ok);
`ifndef SDRAM_ARB_RFSH_EN
        chk("cpu_write_latency", cyc - c0, SLOT + 1);
`endif
        chk("bfm_mem_123", bfm_mem[10'h123], 16'hBEEF);
        #1 cpu_req = 1'b0;
        repeat (3) @(negedge clock);

        // Both ports held: grants alternate video, CPU, video
        #1 vid_issue(22'h2A5A5A);
        cpu_issue(1'b0, 22'h01F00F, 16'h0);
        n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            @(negedge clock);
            if (cpu_ack || vid_ack) begin
                order[n] = vid_ack ? 1 : 0;
                tack[n] = cyc;
                n++;
                #1;
                if (n < 3) begin
                    if (vid_ack) vid_issue(22'($urandom));
                    else cpu_issue(1'b0, 22'($urandom), 16'h0);
                end else begin
                    vid_req = 1'b0;
                end
            end
        end
        if (n < 3) fail("alternation_timeout");
        else begin
            chk("alt_order", {order[0][1:0], order[1][1:0], order[2][1:0]}, 6'b01_00_01);
`ifndef SDRAM_ARB_RFSH_EN
            chk("alt_spacing_1", tack[1] - tack[0], SLOT + 1);
            chk("alt_spacing_2", tack[2] - tack[1], SLOT + 1);
`endif
        end
        wait_cpu_ack(ok);
        #1 cpu_req = 1'b0;
        vid_req = 1'b0;
        repeat (3) @(negedge clock);

        // Reset in the middle of a CPU read
        #1 cpu_issue(1'b0, 22'h00ABCD, 16'h0);
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clock);
            if (mem_rd) ok = 1'b1;
        end
        if (!ok) fail("rd_strobe_timeout");
        @(negedge clock);
        #1 mon_en = 1'b0;
        reset = 1'b1;
        cpu_req = 1'b0;
        #1 chk("reset_drops_rd", mem_rd, 0);
        chk("reset_busy", busy, 1);
        strobe_early = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (cpu_ack || vid_ack || mem_rd) strobe_early = 1'b1;
        end
        chk("no_ack_after_reset", strobe_early, 0);
        cpu_exp.delete();
        vid_exp.delete();
        m_cpu_q = '0; m_vid_q = '0; m_last_vid = 1'b0;
        #1 reset = 1'b0;
        chk("cpu_q_after_reset", cpu_q, 0);
        mon_en = 1'b1;
        cpu_issue(1'b0, 22'h003210, 16'h0);
        c0 = cyc;
        wait_cpu_ack(ok);
        chk("post_reset_latency", cyc - c0, 2 * SLOT + 1);
        #1 cpu_req = 1'b0;
        repeat (3) @(negedge clock);

        // Random traffic on both ports
        #1;
        fork
            run_cpu(350);
            run_vid(350);
        join
        repeat (20) @(negedge clock);
        chk("cpu_queue_drained", cpu_exp.size(), 0);
        chk("vid_queue_drained", vid_exp.size(), 0);
`ifdef SDRAM_ARB_RFSH_EN
        chk("refresh_slots_seen", rfsh_seen > 5, 1);
`else
        chk("rfsh_stays_high", rfsh_bad, 0);
        chk("no_refresh_slots", rfsh_seen, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
